// File: rtl/mul_req_arbiter.sv
// Round-robin arbiter that shares one 32x32 signed multiplier among N_REQ requesters.
// One job is in flight at a time: IDLE -> SETUP -> START -> WAIT -> RESP -> IDLE.
module mul_req_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_id,
    output logic [63:0]           rsp_product,
    output logic                  rsp_error,
    output logic                  mul_start,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic                  mul_done,
    input  logic [63:0]           mul_product,
    output logic                  busy
);

    localparam int unsigned ID_W  = 2;
    localparam int unsigned OP_W  = 32;
    localparam int unsigned SEL_W = $clog2(OP_W * N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    cur_id;
    logic [CNT_W-1:0]   wait_cnt;

    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    rr_idx;
    logic               accept;
    logic [SEL_W-1:0]   sel_base;
    logic               done_ok;
    logic               timeout_hit;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        rr_idx    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            rr_idx = last_grant + ID_W'(k);
            if (!grant_any && req_valid[rr_idx]) begin
                grant_any = 1'b1;
                grant_id  = rr_idx;
            end
        end
    end

    assign accept   = (state == S_IDLE) && !rst && grant_any;
    assign sel_base = SEL_W'(grant_id) * SEL_W'(OP_W);

    // A done seen in the first WAIT cycle may be left over from a previous job.
    assign done_ok     = (state == S_WAIT) && mul_done && (wait_cnt > CNT_W'(1));
    assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    next_state = S_SETUP;
                end
            end
            S_SETUP: next_state = S_START;
            S_START: next_state = S_WAIT;
            S_WAIT: begin
                if (done_ok || timeout_hit) begin
                    next_state = S_RESP;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Registered outputs, job context and WAIT counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= ID_W'(N_REQ - 1);
            cur_id      <= '0;
            wait_cnt    <= '0;
            busy        <= 1'b0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            rsp_error   <= 1'b0;
        end else begin
            busy      <= (next_state != S_IDLE);
            mul_start <= (next_state == S_START);
            rsp_valid <= (next_state == S_RESP);

            if (next_state == S_WAIT) begin
                wait_cnt <= (state == S_WAIT) ? wait_cnt + CNT_W'(1) : CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            // Operands go straight to the multiplier ports and stay there until the next accept.
            if (accept) begin
                last_grant <= grant_id;
                cur_id     <= grant_id;
                mul_a      <= req_a[sel_base +: OP_W];
                mul_b      <= req_b[sel_base +: OP_W];
            end

            if ((state == S_WAIT) && (next_state == S_RESP)) begin
                rsp_id      <= cur_id;
                rsp_product <= done_ok ? mul_product : '0;
                rsp_error   <= !done_ok;
            end
        end
    end

endmodule

// File: tb/tb_mul_req_arbiter.sv
// Randomised self-checking bench for mul_req_arbiter against a transaction-level model,
// with directed jobs whose results are pinned to hand-computed constants.
module tb_mul_req_arbiter;

    localparam int TO     = 20;
    localparam int NORMAL = 0;
    localparam int NEVER  = 1;
    localparam int STALE  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_product;
    logic         rsp_error;
    logic         mul_start;
    logic [31:0]  mul_a;
    logic [31:0]  mul_b;
    logic         mul_done;
    logic [63:0]  mul_product;
    logic         busy;

    always #5 clk = ~clk;

    mul_req_arbiter #(.N_REQ(4), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_error   (rsp_error),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Stimulus: requester intentions and multiplier behaviour
    bit          g_rst;
    bit          g_hold;
    int          mm_mode;
    int          mm_lat;
    bit          pend_v [4];
    logic [31:0] pend_a [4];
    logic [31:0] pend_b [4];
    bit          mm_started;
    int          mm_s;
    logic [63:0] mm_prod;

    // Reference model: one job in flight, timed relative to its accept cycle
    bit          m_job;
    int          m_t;
    int          m_resp_at;
    logic [1:0]  m_last;
    logic [1:0]  m_id;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [63:0] p_prod;
    bit          p_err;
    logic [31:0] e_mul_a;
    logic [31:0] e_mul_b;
    logic [1:0]  e_rsp_id;
    logic [63:0] e_rsp_prod;
    bit          e_rsp_err;

    logic [1:0]  rsp_ids   [$];
    logic [63:0] rsp_prods [$];
    bit          rsp_errs  [$];
    int          rsp_cycs  [$];
    int          acc_ids   [$];
    int          acc_cycs  [$];
    int          last_start;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] smul(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = a;
        y = b;
        return x * y;
    endfunction

    function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] last);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (int'(last) + k) % 4;
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_job      = 1'b0;
        m_t        = 0;
        m_resp_at  = -1;
        m_last     = 2'd3;
        m_id       = 2'd0;
        m_a        = '0;
        m_b        = '0;
        e_mul_a    = '0;
        e_mul_b    = '0;
        e_rsp_id   = '0;
        e_rsp_prod = '0;
        e_rsp_err  = 1'b0;
        mm_started = 1'b0;
    endtask

    // One clock: drive at the falling edge, check settled outputs, then advance the model.
    task automatic step();
        logic [3:0] exp_ready;
        logic [3:0] acc;
        logic [1:0] w;
        bit         exp_busy;
        bit         exp_start;
        bit         exp_rv;
        int         k;
        @(negedge clk);
        cyc++;
        rst = g_rst;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]         = pend_v[i];
            req_a[32*i +: 32]    = pend_a[i];
            req_b[32*i +: 32]    = pend_b[i];
        end
        case (mm_mode)
            NEVER: begin
                mul_done    = 1'b0;
                mul_product = {$urandom, $urandom};
            end
            STALE: begin
                mul_done    = 1'b1;
                mul_product = (mm_started && (cyc - mm_s >= 2)) ? mm_prod : {$urandom, $urandom};
            end
            default: begin
                mul_done    = mm_started && (cyc - mm_s >= mm_lat);
                mul_product = mul_done ? mm_prod : {$urandom, $urandom};
            end
        endcase
        #1;
        exp_ready = '0;
        exp_busy  = 1'b0;
        exp_start = 1'b0;
        exp_rv    = 1'b0;
        k         = 0;
        if (!m_job) begin
            if (!g_rst && (req_valid != 4'd0)) exp_ready = 4'b0001 << rr_pick(req_valid, m_last);
        end else begin
            k         = cyc - m_t;
            exp_busy  = 1'b1;
            exp_start = (k == 2);
            exp_rv    = (cyc == m_resp_at);
            if (exp_rv) begin
                e_rsp_id   = m_id;
                e_rsp_prod = p_prod;
                e_rsp_err  = p_err;
            end
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("mul_start", 64'(mul_start), 64'(exp_start));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        chk("mul_a", 64'(mul_a), 64'(e_mul_a));
        chk("mul_b", 64'(mul_b), 64'(e_mul_b));
        chk("rsp_id", 64'(rsp_id), 64'(e_rsp_id));
        chk("rsp_product", rsp_product, e_rsp_prod);
        chk("rsp_error", 64'(rsp_error), 64'(e_rsp_err));

        acc = req_valid & req_ready;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                acc_ids.push_back(i);
                acc_cycs.push_back(cyc);
            end
        end
        if (rsp_valid === 1'b1) begin
            rsp_ids.push_back(rsp_id);
            rsp_prods.push_back(rsp_product);
            rsp_errs.push_back(rsp_error);
            rsp_cycs.push_back(cyc);
        end
        if (mul_start === 1'b1) last_start = cyc;

        if (g_rst) begin
            model_reset();
        end else if (!m_job) begin
            if (exp_ready != 4'd0) begin
                w         = rr_pick(req_valid, m_last);
                m_job     = 1'b1;
                m_t       = cyc;
                m_id      = w;
                m_last    = w;
                m_a       = pend_a[w];
                m_b       = pend_b[w];
                e_mul_a   = pend_a[w];
                e_mul_b   = pend_b[w];
                m_resp_at = -1;
            end
        end else if (cyc == m_resp_at) begin
            m_job = 1'b0;
        end else if ((m_resp_at < 0) && (k >= 3)) begin
            if ((k >= 4) && mul_done) begin
                m_resp_at = cyc + 1;
                p_prod    = smul(m_a, m_b);
                p_err     = 1'b0;
            end else if (k - 2 >= TO) begin
                m_resp_at = cyc + 1;
                p_prod    = '0;
                p_err     = 1'b1;
            end
        end

        if (!g_rst && (mul_start === 1'b1)) begin
            mm_started = 1'b1;
            mm_s       = cyc;
            mm_prod    = smul(mul_a, mul_b);
        end
        if (!g_hold) begin
            for (int i = 0; i < 4; i++) if (acc[i]) pend_v[i] = 1'b0;
        end
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic [31:0] b);
        pend_v[i] = 1'b1;
        pend_a[i] = a;
        pend_b[i] = b;
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name, output bit ok);
        int b;
        b = budget;
        while ((rsp_cycs.size() < target) && (b > 0)) begin
            step();
            b--;
        end
        ok = (rsp_cycs.size() >= target);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got %0d responses, expected %0d within %0d cycles", name, rsp_cycs.size(), target, budget);
        end
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [63:0] cont_exp [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        bit ok;
        int rb;
        int ab;
        cont_exp = '{64'd0, -64'sd14, -64'sd42, -64'sd84, 64'd0};
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        mul_done = 1'b0;
        mul_product = '0;
        g_rst = 1'b1;
        g_hold = 1'b0;
        mm_mode = NORMAL;
        mm_lat = 2;
        mm_s = 0;
        mm_prod = '0;
        p_prod = '0;
        p_err = 1'b0;
        last_start = 0;
        for (int i = 0; i < 4; i++) begin
            pend_v[i] = 1'b0;
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        model_reset();
        @(posedge clk);
        repeat (2) step();
        g_rst = 1'b0;
        step();

        // Single job, multiplier done three cycles after start
        rb = rsp_cycs.size();
        ab = acc_cycs.size();
        mm_lat = 3;
        req(0, 32'd12, 32'd10);
        wait_rsp(rb + 1, 40, "single_wait", ok);
        repeat (3) step();
        chk("single_count", 64'(rsp_cycs.size() - rb), 64'd1);
        if (ok) begin
            chk("single_id", 64'(rsp_ids[rb]), 64'd0);
            chk("single_prod", rsp_prods[rb], 64'd120);
            chk("single_err", 64'(rsp_errs[rb]), 64'd0);
            chk("single_latency", 64'(rsp_cycs[rb] - acc_cycs[ab]), 64'd6);
        end

        // Contention from a fresh reset: all four requesters keep requesting
        g_rst = 1'b1;
        step();
        g_rst = 1'b0;
        g_hold = 1'b1;
        mm_lat = 2;
        rb = rsp_cycs.size();
        for (int i = 0; i < 4; i++) req(i, 32'(i * 7), 32'(-(i + 1)));
        wait_rsp(rb + 5, 80, "contention_wait", ok);
        g_hold = 1'b0;
        for (int i = 0; i < 4; i++) pend_v[i] = 1'b0;
        if (ok) begin
            for (int j = 0; j < 5; j++) begin
                chk("contention_id", 64'(rsp_ids[rb + j]), 64'(j % 4));
                chk("contention_prod", rsp_prods[rb + j], cont_exp[j]);
            end
        end
        repeat (2) step();

        // Operand extremes at minimum latency
        rb = rsp_cycs.size();
        ab = acc_cycs.size();
        req(1, 32'h8000_0000, 32'h8000_0000);
        wait_rsp(rb + 1, 30, "ext1_wait", ok);
        if (ok) begin
            chk("ext1_prod", rsp_prods[rb], 64'h4000_0000_0000_0000);
            chk("ext1_id", 64'(rsp_ids[rb]), 64'd1);
            chk("ext1_latency", 64'(rsp_cycs[rb] - acc_cycs[ab]), 64'd5);
        end
        step();
        rb = rsp_cycs.size();
        req(2, 32'h7FFF_FFFF, 32'd2);
        wait_rsp(rb + 1, 30, "ext2_wait", ok);
        if (ok) chk("ext2_prod", rsp_prods[rb], 64'h0000_0000_FFFF_FFFE);
        step();

        // Timeout, then a normal job
        rb = rsp_cycs.size();
        mm_mode = NEVER;
        req(3, 32'd5, 32'd9);
        wait_rsp(rb + 1, TO + 30, "timeout_wait", ok);
        if (ok) begin
            chk("timeout_err", 64'(rsp_errs[rb]), 64'd1);
            chk("timeout_prod", rsp_prods[rb], 64'd0);
            chk("timeout_latency", 64'(rsp_cycs[rb] - last_start), 64'(TO + 1));
        end
        mm_mode = NORMAL;
        rb = rsp_cycs.size();
        req(0, 32'd3, -32'sd5);
        wait_rsp(rb + 1, 30, "after_timeout_wait", ok);
        if (ok) begin
            chk("after_timeout_prod", rsp_prods[rb], -64'sd15);
            chk("after_timeout_err", 64'(rsp_errs[rb]), 64'd0);
        end
        step();

        // Stale done held high through START and the first WAIT cycle
        rb = rsp_cycs.size();
        ab = acc_cycs.size();
        mm_mode = STALE;
        req(1, 32'd6, 32'd7);
        wait_rsp(rb + 1, 30, "stale_wait", ok);
        if (ok) begin
            chk("stale_prod", rsp_prods[rb], 64'd42);
            chk("stale_latency", 64'(rsp_cycs[rb] - acc_cycs[ab]), 64'd5);
        end
        mm_mode = NORMAL;
        step();

        // Reset while the job sits in WAIT
        rb = rsp_cycs.size();
        mm_mode = NEVER;
        req(2, 32'd11, 32'd13);
        repeat (5) step();
        g_rst = 1'b1;
        step();
        g_rst = 1'b0;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_rsp_product", rsp_product, 64'd0);
        repeat (TO + 5) step();
        chk("rst_no_rsp", 64'(rsp_cycs.size() - rb), 64'd0);
        mm_mode = NORMAL;
        ab = acc_cycs.size();
        for (int i = 0; i < 4; i++) req(i, 32'(i + 1), 32'(i + 2));
        step();
        chk("rst_first_accepts", 64'(acc_cycs.size() - ab), 64'd1);
        if (acc_cycs.size() > ab) chk("rst_first_grant", 64'(acc_ids[ab]), 64'd0);
        wait_rsp(rb + 4, 60, "rst_drain", ok);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 24) == 0) mm_lat = $urandom_range(1, 5);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 9))
                    0:       mm_mode = NEVER;
                    1, 2:    mm_mode = STALE;
                    default: mm_mode = NORMAL;
                endcase
            end
            for (int i = 0; i < 4; i++) begin
                if (!pend_v[i] && ($urandom_range(0, 3) == 0)) begin
                    req(i, rand_op(), rand_op());
                end else if (pend_v[i] && ($urandom_range(0, 40) == 0)) begin
                    pend_v[i] = 1'b0;
                end
            end
            step();
        end
        for (int i = 0; i < 4; i++) pend_v[i] = 1'b0;
        mm_mode = NORMAL;
        repeat (TO + 10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_req_arbiter.md
MUL_REQ_ARBITER -- requirements
Module: mul_req_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, the number of requesters (fixed at 4 for this release; ids are 2 bits).
REQ-002 SHALL have parameter TIMEOUT, default 100, the maximum WAIT cycles before a job is aborted.
REQ-003 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  4  per-requester job request.
REQ-006 SHALL have port req_a  input  128  packed signed 32-bit operand A; requester i uses bits [32i+31:32i].
REQ-007 SHALL have port req_b  input  128  packed signed 32-bit operand B, same packing as req_a.
REQ-008 SHALL have port req_ready  output  4  one-hot accept strobe; requester i is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle result strobe.
REQ-010 SHALL have port rsp_id  output  2  index of the requester that owns the result.
REQ-011 SHALL have port rsp_product  output  64  signed product.
REQ-012 SHALL have port rsp_error  output  1  job aborted by timeout.
REQ-013 SHALL have port mul_start  output  1  start pulse to the shared 32x32 multiplier.
REQ-014 SHALL have ports mul_a and mul_b  output  32 each  multiplier operands.
REQ-015 SHALL have port mul_done  input  1  multiplier completion, treated as a level.
REQ-016 SHALL have port mul_product  input  64  multiplier result.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, SETUP, START, WAIT and RESP, with one state transition per clock.
REQ-019 IDLE SHALL behave as follows:
- if any req_valid bit is high, assert req_ready for the round-robin winner in the same cycle (combinational from req_valid and the pointer);
- latch that requester's operands and id;
- go to SETUP.
REQ-020 Round-robin SHALL search from (last_grant+1) mod 4 upward, wrapping; last_grant updates on every accept.
REQ-021 req_ready SHALL be all-zero outside IDLE; requests that are not granted are held by their requesters and are not lost.
REQ-022 SETUP SHALL drive mul_a and mul_b from the latched operands with mul_start=0, then go to START; this guarantees a start rising edge with stable operands.
REQ-023 START SHALL hold mul_start=1 for exactly one cycle, then go to WAIT.
REQ-024 mul_a and mul_b SHALL remain stable from SETUP through the end of WAIT.
REQ-025 WAIT SHALL behave as follows:
- ignore mul_done in the first WAIT cycle, to reject a stale done;
- from the second WAIT cycle on, mul_done=1 captures mul_product and the FSM goes to RESP.
REQ-026 A WAIT cycle counter SHALL start at 1 in the first WAIT cycle; when it reaches TIMEOUT without a done, the FSM goes to RESP with the error flag set and product 0.
REQ-027 RESP SHALL assert rsp_valid for one cycle with rsp_id, rsp_product and rsp_error, then return to IDLE.
REQ-028 rsp_id, rsp_product and rsp_error SHALL hold their values until the next RESP.
REQ-029 Minimum latency SHALL be 5 cycles from accept to rsp_valid: accept (IDLE) at cycle T, SETUP T+1, START T+2, WAIT from T+3, rsp_valid at T+5 when done is high at T+4.
REQ-030 New requests SHALL be accepted only in IDLE, so back-to-back jobs are separated by one IDLE cycle; there is no preemption.
REQ-031 When requests arrive simultaneously, exactly one is granted per IDLE visit, in round-robin order.
REQ-032 A req_valid that drops before it is granted SHALL have no effect.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL:
- enter IDLE, even mid-job;
- set last_grant=3, so requester 0 has first priority;
- clear the WAIT cycle counter;
- drive req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, rsp_error=0, mul_start=0, mul_a=0, mul_b=0 and busy=0.
REQ-034 A job aborted by reset SHALL produce no response, and no stale response SHALL be emitted after reset.

Verification
REQ-035 Single job: req_valid=0001, A=12, B=10, multiplier model with done after 3 cycles -> rsp_valid once, rsp_id=0, rsp_product=120, rsp_error=0.
REQ-036 Contention: req_valid=1111 held, operands i*7 and -(i+1) -> grant order 0,1,2,3,0, products 0, -14, -42, -84, with correct rsp_id each time.
REQ-037 Extremes: A=0x80000000, B=0x80000000 -> rsp_product=0x4000000000000000; A=0x7FFFFFFF, B=2 -> 0x00000000FFFFFFFE.
REQ-038 Timeout: the model never asserts done -> rsp_valid with rsp_error=1 and rsp_product=0 exactly TIMEOUT WAIT cycles after START, then the next request is served normally.
REQ-039 Stale done: the model holds mul_done=1 before and during START -> no capture in the first WAIT cycle, and the result is taken only from a done seen in the second WAIT cycle or later.
REQ-040 Reset mid-job: assert rst during WAIT -> all outputs are zero on the next cycle, no rsp_valid for that job, and a fresh request is granted to requester 0 first.
